uart_rx_arb: RTL and testbench

- Round-robin arbiter that merges N independent UART receive frame streams (64-bit AXIS) onto one AXIS output toward the frame-processing core.
- Each requester is one UART receiver's frame output. The arbiter tags each forwarded frame with its source port index.
- One registered output stage provides full throughput of one frame per cycle.

---
 rtl/uart_rx_arb.sv | 106 ++++++++++
 tb/tb_uart_rx_arb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_arb.sv
// Round-robin merge of N UART rx frame streams onto one AXIS output tagged with source index; UART_RX_ARB_STATS_EN adds per-port grant counters.
// Latency: one cycle from input handshake to output valid; one frame per cycle sustained.
// Backpressure: while the output register is full and m_axis_tready is low, every s_axis_tready is held low.
module uart_rx_arb #(
  parameter int N_PORTS     = 4,
  parameter int FRAME_WIDTH = 64,
  parameter int DEST_WIDTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS*FRAME_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]             s_axis_tvalid,
  output logic [N_PORTS-1:0]             s_axis_tready,
  output logic [FRAME_WIDTH-1:0]         m_axis_tdata,
  output logic [DEST_WIDTH-1:0]          m_axis_tdest,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready
`ifdef UART_RX_ARB_STATS_EN
  ,
  output logic [N_PORTS*16-1:0]          grant_count
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [DEST_WIDTH:0] NP = (DEST_WIDTH+1)'(N_PORTS);

  state_t                  state, state_nxt;
  logic [DEST_WIDTH-1:0]   last_grant;
  logic [DEST_WIDTH:0]     start, off, sum;
  logic [N_PORTS-1:0]      rot;
  logic                    grant_vld, load_ok, do_grant;
  logic [DEST_WIDTH-1:0]   grant_idx;
  logic [FRAME_WIDTH-1:0]  frames [N_PORTS];

  // Rotate valids so bit 0 is the port just after last_grant; the lowest set bit wins.
  assign start = {1'b0, last_grant} + (DEST_WIDTH+1)'(1);

  always_comb begin
    rot       = N_PORTS'({s_axis_tvalid, s_axis_tvalid} >> start);
    grant_vld = 1'b0;
    off       = '0;
    for (int k = N_PORTS-1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_vld = 1'b1;
        off       = (DEST_WIDTH+1)'(k);
      end
    end
    sum       = start + off;
    grant_idx = (sum >= NP) ? DEST_WIDTH'(sum - NP) : DEST_WIDTH'(sum);
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      frames[i] = s_axis_tdata[i*FRAME_WIDTH +: FRAME_WIDTH];
    end
  end

  assign load_ok       = (state == EMPTY) || m_axis_tready;
  assign do_grant      = load_ok && grant_vld && !rst;
  assign s_axis_tready = do_grant ? (N_PORTS'(1) << grant_idx) : '0;
  assign m_axis_tvalid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (do_grant) state_nxt = FULL;
      FULL:  if (m_axis_tready && !do_grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tdata <= '0;
      m_axis_tdest <= '0;
      last_grant   <= DEST_WIDTH'(N_PORTS-1);
    end else if (do_grant) begin
      m_axis_tdata <= frames[grant_idx];
      m_axis_tdest <= grant_idx;
      last_grant   <= grant_idx;
    end
  end

`ifdef UART_RX_ARB_STATS_EN
  logic [N_PORTS-1:0][15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (s_axis_tready[i]) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  assign grant_count = cnt;
`endif

endmodule

// File: tb/tb_uart_rx_arb.sv
// Directed bench for uart_rx_arb: reset, single request, round-robin, backpressure, fairness, mid-run reset.
module tb_uart_rx_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_axis_tdata;
  logic [3:0]   s_axis_tvalid;
  logic [3:0]   s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [1:0]   m_axis_tdest;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
`ifdef UART_RX_ARB_STATS_EN
  logic [63:0]  grant_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_arb #(.N_PORTS(4), .FRAME_WIDTH(64), .DEST_WIDTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef UART_RX_ARB_STATS_EN
    ,
    .grant_count   (grant_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frames(input logic [63:0] f0, input logic [63:0] f1,
                            input logic [63:0] f2, input logic [63:0] f3);
    s_axis_tdata = {f3, f2, f1, f0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] fair_dest [4];
    fair_dest = '{2'd0, 2'd2, 2'd0, 2'd2};

    // Reset: outputs cleared and no tready even with every port valid.
    rst = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 4'hF;
    set_frames(64'h11, 64'h22, 64'h33, 64'h44);
    next_cycle();
    chk("rst_tready", 64'(s_axis_tready), 64'h0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("rst_tdata",  m_axis_tdata, 64'h0);
    chk("rst_tdest",  64'(m_axis_tdest), 64'h0);
    rst = 1'b0;
    s_axis_tvalid = 4'h0;
    next_cycle();

    // Single request on port 2.
    set_frames(64'h0, 64'h0, 64'h0123456789ABCDEF, 64'h0);
    s_axis_tvalid = 4'b0100;
    #1;
    chk("single_tready", 64'(s_axis_tready), 64'h4);
    next_cycle();
    s_axis_tvalid = 4'b0000;
    #1;
    chk("single_tvalid", 64'(m_axis_tvalid), 64'h1);
    chk("single_tdata",  m_axis_tdata, 64'h0123456789ABCDEF);
    chk("single_tdest",  64'(m_axis_tdest), 64'h2);
    chk("single_idle_tready", 64'(s_axis_tready), 64'h0);
    next_cycle();
    chk("single_drain", 64'(m_axis_tvalid), 64'h0);

    // All four valid after reset: served 0,1,2,3 back-to-back, each dropping once accepted.
    do_reset();
    set_frames(64'hA0, 64'hA1, 64'hA2, 64'hA3);
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 4'(4'hF << i);
      #1;
      chk($sformatf("rr_tready%0d", i), 64'(s_axis_tready), 64'(4'(1) << i));
      next_cycle();
      chk($sformatf("rr_tvalid%0d", i), 64'(m_axis_tvalid), 64'h1);
      chk($sformatf("rr_tdata%0d", i),  m_axis_tdata, 64'hA0 + 64'(i));
      chk($sformatf("rr_tdest%0d", i),  64'(m_axis_tdest), 64'(i));
    end
    s_axis_tvalid = 4'h0;
    next_cycle();
    chk("rr_drain", 64'(m_axis_tvalid), 64'h0);

    // Backpressure: last grant was 3, so port 1 wins first, then stalls for 10 cycles.
    set_frames(64'h0, 64'hB1, 64'h0, 64'hB3);
    s_axis_tvalid = 4'b1010;
    #1;
    chk("bp_first_tready", 64'(s_axis_tready), 64'h2);
    next_cycle();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("bp_tready%0d", i), 64'(s_axis_tready), 64'h0);
      chk($sformatf("bp_tdata%0d", i),  m_axis_tdata, 64'hB1);
      chk($sformatf("bp_tdest%0d", i),  64'(m_axis_tdest), 64'h1);
      chk($sformatf("bp_tvalid%0d", i), 64'(m_axis_tvalid), 64'h1);
      next_cycle();
    end
    m_axis_tready = 1'b1;
    #1;
    chk("bp_release_tready", 64'(s_axis_tready), 64'h8);
    next_cycle();
    chk("bp_release_tdest", 64'(m_axis_tdest), 64'h3);
    chk("bp_release_tdata", m_axis_tdata, 64'hB3);
    set_frames(64'h0, 64'hC1, 64'h0, 64'h0);
    s_axis_tvalid = 4'b0010;
    #1;
    chk("bp_wrap_tready", 64'(s_axis_tready), 64'h2);
    next_cycle();
    chk("bp_wrap_tdest", 64'(m_axis_tdest), 64'h1);
    chk("bp_wrap_tdata", m_axis_tdata, 64'hC1);
    s_axis_tvalid = 4'h0;
    next_cycle();

    // Fairness: ports 0 and 2 held valid alternate.
    do_reset();
    set_frames(64'hD0, 64'h0, 64'hD2, 64'h0);
    s_axis_tvalid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fair_tready%0d", i), 64'(s_axis_tready), 64'(4'(1) << fair_dest[i]));
      next_cycle();
      chk($sformatf("fair_tdest%0d", i), 64'(m_axis_tdest), 64'(fair_dest[i]));
      chk($sformatf("fair_tdata%0d", i), m_axis_tdata, (fair_dest[i] == 2'd0) ? 64'hD0 : 64'hD2);
    end

    // Mid-run reset while holding a port-1 frame.
    set_frames(64'hE0, 64'hE1, 64'hE2, 64'hE3);
    s_axis_tvalid = 4'b0010;
    next_cycle();
    chk("mid_pre_tdest", 64'(m_axis_tdest), 64'h1);
    rst = 1'b1;
    s_axis_tvalid = 4'hF;
    #1;
    chk("mid_rst_tready", 64'(s_axis_tready), 64'h0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("mid_post_tvalid", 64'(m_axis_tvalid), 64'h0);
    chk("mid_post_tready", 64'(s_axis_tready), 64'h1);
    next_cycle();
    chk("mid_post_tdest", 64'(m_axis_tdest), 64'h0);
    chk("mid_post_tdata", m_axis_tdata, 64'hE0);

`ifdef UART_RX_ARB_STATS_EN
    // Five handshakes from port 3 only.
    do_reset();
    s_axis_tvalid = 4'b1000;
    for (int i = 0; i < 5; i++) next_cycle();
    s_axis_tvalid = 4'h0;
    next_cycle();
    chk("stats_port3", 64'(grant_count[63:48]), 64'd5);
    chk("stats_others", 64'(grant_count[47:0]), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
